dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 7 +
 rtl/arb_starve_cnt.sv | 23 ++
 rtl/dmem_arbiter.sv | 102 ++++++++++
 tb/tb_dmem_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared FSM state type, owner tags and counter width for dmem_arbiter
package dmem_arb_pkg;
    localparam int CNT_W = 8;
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_EXT = 1'b1;
    typedef enum logic {ARB, EXT_BURST} state_t;
endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: saturating count of cycles the external port waits ungranted
module arb_starve_cnt
    import dmem_arb_pkg::*;
#(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ext_req,
    input  logic ext_gnt,
    output logic at_limit
);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        at_limit = cnt_q == LIM;
        cnt_d = (!ext_req || ext_gnt) ? '0 : at_limit ? cnt_q : cnt_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU/external-loader arbiter for a single-port data SRAM.
// Optional grant/stall statistics outputs when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    input  logic              ext_lock,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0]       stat_cpu_gnt,
    output logic [31:0]       stat_ext_gnt,
    output logic [31:0]       stat_stall,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);
    state_t state_q, state_d;
    logic pend_q, pend_d, tag_q, tag_d;
    logic at_limit, in_arb, gnt_we, any_gnt;

    arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_cnt (
        .clk(clk), .rst(rst), .ext_req(ext_req), .ext_gnt(ext_gnt), .at_limit(at_limit)
    );

    always_comb begin
        in_arb = state_q == ARB;
        ext_gnt = ext_req & (in_arb ? (at_limit | ~cpu_req) : 1'b1);
        cpu_gnt = in_arb & cpu_req & ~ext_gnt;
        cpu_stall = cpu_req & ~cpu_gnt;
        any_gnt = cpu_gnt | ext_gnt;
        gnt_we = ext_gnt ? ext_we : cpu_we;
        mem_wen = any_gnt & gnt_we;
        mem_ren = any_gnt & ~gnt_we;
        mem_addr = ext_gnt ? ext_addr : cpu_gnt ? cpu_addr : '0;
        mem_wdata = ext_gnt ? ext_wdata : cpu_gnt ? cpu_wdata : '0;
        state_d = (in_arb ? (ext_gnt & ext_lock) : ext_lock) ? EXT_BURST : ARB;
        pend_d = mem_ren;
        tag_d = mem_ren ? (ext_gnt ? OWN_EXT : OWN_CPU) : tag_q;
        // a read in flight is dropped as soon as reset is seen
        cpu_rvalid = pend_q & ~rst & (tag_q == OWN_CPU);
        ext_rvalid = pend_q & ~rst & (tag_q == OWN_EXT);
        cpu_rdata = cpu_rvalid ? mem_rdata : '0;
        ext_rdata = ext_rvalid ? mem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            pend_q <= 1'b0;
            tag_q <= OWN_CPU;
        end else begin
            state_q <= state_d;
            pend_q <= pend_d;
            tag_q <= tag_d;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] scpu_q, scpu_d, sext_q, sext_d, sstl_q, sstl_d;
    always_comb begin
        scpu_d = scpu_q + 32'(cpu_gnt);
        sext_d = sext_q + 32'(ext_gnt);
        sstl_d = sstl_q + 32'(cpu_stall);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            scpu_q <= '0;
            sext_q <= '0;
            sstl_q <= '0;
        end else begin
            scpu_q <= scpu_d;
            sext_q <= sext_d;
            sstl_q <= sstl_d;
        end
    end
    assign stat_cpu_gnt = scpu_q;
    assign stat_ext_gnt = sext_q;
    assign stat_stall = sstl_q;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter (STARVE_LIMIT = 8).
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;
    logic clk, rst;
    logic cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
    logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic ext_req, ext_we, ext_lock, ext_gnt, ext_rvalid;
    logic [63:0] ext_addr, ext_wdata, ext_rdata;
    logic mem_wen, mem_ren;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_cpu_gnt, stat_ext_gnt, stat_stall;
`endif
    int n_cmp = 0;
    int n_fail = 0;

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_lock(ext_lock), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef DMEM_ARB_STATS_EN
        .stat_cpu_gnt(stat_cpu_gnt), .stat_ext_gnt(stat_ext_gnt), .stat_stall(stat_stall),
`endif
        .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0; ext_lock = 0;
        mem_rdata = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        idle();
        do_reset();
        #1;
        n_cmp++;
        if ({cpu_rvalid, ext_rvalid, cpu_gnt, ext_gnt, mem_wen, mem_ren} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000000", {cpu_rvalid, ext_rvalid, cpu_gnt, ext_gnt, mem_wen, mem_ren});
        end
        n_cmp++;
        if ({cpu_rdata, ext_rdata, mem_addr, mem_wdata} !== 256'b0) begin
            n_fail++;
            $display("FAIL reset_data: cpu_rdata=%h ext_rdata=%h mem_addr=%h want 0", cpu_rdata, ext_rdata, mem_addr);
        end
        n_cmp++;
        if (dut.state_q !== ARB || dut.u_cnt.cnt_q !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d cnt=%0d want 0/0", dut.state_q, dut.u_cnt.cnt_q);
        end
        step();
    endtask

    task automatic test_cpu_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 64'h10;
        #1;
        n_cmp++;
        if ({cpu_gnt, ext_gnt, mem_ren, mem_wen, cpu_stall} !== 5'b10100 || mem_addr !== 64'h10) begin
            n_fail++;
            $display("FAIL cpu_read_issue: gnt/ren/wen/stall=%b addr=%h want 10100 addr=10", {cpu_gnt, ext_gnt, mem_ren, mem_wen, cpu_stall}, mem_addr);
        end
        step();
        idle();
        mem_rdata = 64'h0000_CAFE_F00D_1234;
        #1;
        n_cmp++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 64'h0000_CAFE_F00D_1234 || ext_rvalid !== 1'b0 || ext_rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL cpu_read_return: rvalid=%b rdata=%h ext_rvalid=%b ext_rdata=%h want 1/0000cafef00d1234/0/0", cpu_rvalid, cpu_rdata, ext_rvalid, ext_rdata);
        end
        step();
        #1;
        n_cmp++;
        if (cpu_rvalid !== 1'b0 || cpu_rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL cpu_read_single: rvalid=%b rdata=%h want 0/0", cpu_rvalid, cpu_rdata);
        end
    endtask

    task automatic test_cpu_write();
        idle();
        cpu_req = 1; cpu_we = 1; cpu_addr = 64'h20; cpu_wdata = 64'h55AA;
        #1;
        n_cmp++;
        if ({cpu_gnt, mem_wen, mem_ren} !== 3'b110 || mem_addr !== 64'h20 || mem_wdata !== 64'h55AA) begin
            n_fail++;
            $display("FAIL cpu_write: gnt/wen/ren=%b addr=%h wdata=%h want 110/20/55aa", {cpu_gnt, mem_wen, mem_ren}, mem_addr, mem_wdata);
        end
        step();
        idle();
        mem_rdata = 64'h1111;
        #1;
        n_cmp++;
        if ({cpu_rvalid, ext_rvalid, mem_wen, mem_ren} !== 4'b0 || mem_addr !== 64'h0 || mem_wdata !== 64'h0) begin
            n_fail++;
            $display("FAIL write_no_rvalid: rv/strobes=%b addr=%h wdata=%h want 0000/0/0", {cpu_rvalid, ext_rvalid, mem_wen, mem_ren}, mem_addr, mem_wdata);
        end
        step();
    endtask

    task automatic test_starvation();
        idle();
        do_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 64'h40;
        ext_req = 1; ext_we = 1; ext_addr = 64'h80;
        for (int c = 1; c <= 18; c++) begin
            logic e;
            e = (c == 9) || (c == 18);
            #1;
            n_cmp++;
            if ({cpu_gnt, ext_gnt, cpu_stall, mem_wen} !== {~e, e, e, 1'b1} || mem_addr !== (e ? 64'h80 : 64'h40)) begin
                n_fail++;
                $display("FAIL starve_c%0d: cpu/ext/stall/wen=%b addr=%h want %b addr=%h", c, {cpu_gnt, ext_gnt, cpu_stall, mem_wen}, mem_addr, {~e, e, e, 1'b1}, e ? 64'h80 : 64'h40);
            end
            if (c == 10) begin
                n_cmp++;
                if (dut.u_cnt.cnt_q !== 8'd0) begin
                    n_fail++;
                    $display("FAIL starve_cnt_clear: cnt=%0d want 0", dut.u_cnt.cnt_q);
                end
            end
            step();
        end
        idle();
`ifdef DMEM_ARB_STATS_EN
        #1;
        n_cmp++;
        if (stat_cpu_gnt !== 32'd16 || stat_ext_gnt !== 32'd2 || stat_stall !== 32'd2) begin
            n_fail++;
            $display("FAIL stats: cpu=%0d ext=%0d stall=%0d want 16/2/2", stat_cpu_gnt, stat_ext_gnt, stat_stall);
        end
`endif
        step();
    endtask

    task automatic test_burst();
        idle();
        do_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 64'h44;
        ext_we = 1; ext_addr = 64'h88;
        for (int c = 1; c <= 14; c++) begin
            logic e, p, s;
            ext_req = (c != 11) && (c != 14);
            ext_lock = (c != 13) && (c != 14);
            ext_wdata = 64'(c);
            e = (c == 9) || (c == 10) || (c == 12) || (c == 13);
            p = (c <= 8) || (c == 14);
            s = (c >= 10) && (c <= 13);
            #1;
            n_cmp++;
            if ({cpu_gnt, ext_gnt, cpu_stall, mem_wen, mem_ren} !== {p, e, ~p, p | e, 1'b0}) begin
                n_fail++;
                $display("FAIL burst_c%0d: cpu/ext/stall/wen/ren=%b want %b", c, {cpu_gnt, ext_gnt, cpu_stall, mem_wen, mem_ren}, {p, e, ~p, p | e, 1'b0});
            end
            if (c >= 10) begin
                n_cmp++;
                if (dut.state_q !== (s ? EXT_BURST : ARB)) begin
                    n_fail++;
                    $display("FAIL burst_state_c%0d: state=%0d want %0d", c, dut.state_q, s);
                end
            end
            if (e) begin
                n_cmp++;
                if (mem_addr !== 64'h88 || mem_wdata !== 64'(c)) begin
                    n_fail++;
                    $display("FAIL burst_data_c%0d: addr=%h wdata=%h want 88/%h", c, mem_addr, mem_wdata, c);
                end
            end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_alternate();
        idle();
        cpu_req = 1; cpu_addr = 64'h100;
        #1;
        n_cmp++;
        if ({cpu_gnt, mem_ren} !== 2'b11 || mem_addr !== 64'h100) begin
            n_fail++;
            $display("FAIL alt_cpu1_issue: gnt/ren=%b addr=%h want 11/100", {cpu_gnt, mem_ren}, mem_addr);
        end
        step();
        idle();
        ext_req = 1; ext_addr = 64'h200; mem_rdata = 64'hD1D1;
        #1;
        n_cmp++;
        if ({ext_gnt, mem_ren, cpu_rvalid, ext_rvalid} !== 4'b1110 || mem_addr !== 64'h200 || cpu_rdata !== 64'hD1D1 || ext_rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL alt_cpu1_ret: flags=%b addr=%h cpu_rdata=%h ext_rdata=%h want 1110/200/d1d1/0", {ext_gnt, mem_ren, cpu_rvalid, ext_rvalid}, mem_addr, cpu_rdata, ext_rdata);
        end
        step();
        idle();
        cpu_req = 1; cpu_addr = 64'h300; mem_rdata = 64'hD2D2;
        #1;
        n_cmp++;
        if ({cpu_gnt, mem_ren, cpu_rvalid, ext_rvalid} !== 4'b1101 || mem_addr !== 64'h300 || ext_rdata !== 64'hD2D2 || cpu_rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL alt_ext_ret: flags=%b addr=%h ext_rdata=%h cpu_rdata=%h want 1101/300/d2d2/0", {cpu_gnt, mem_ren, cpu_rvalid, ext_rvalid}, mem_addr, ext_rdata, cpu_rdata);
        end
        step();
        idle();
        mem_rdata = 64'hD3D3;
        #1;
        n_cmp++;
        if ({cpu_rvalid, ext_rvalid} !== 2'b10 || cpu_rdata !== 64'hD3D3 || ext_rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL alt_cpu2_ret: rv=%b cpu_rdata=%h ext_rdata=%h want 10/d3d3/0", {cpu_rvalid, ext_rvalid}, cpu_rdata, ext_rdata);
        end
        step();
    endtask

    task automatic test_reset_inflight();
        idle();
        ext_req = 1; ext_lock = 1; ext_addr = 64'h400;
        #1;
        n_cmp++;
        if ({ext_gnt, mem_ren} !== 2'b11) begin
            n_fail++;
            $display("FAIL inflight_issue: ext_gnt/ren=%b want 11", {ext_gnt, mem_ren});
        end
        step();
        rst = 1; cpu_req = 1; mem_rdata = 64'hBAD0;
        #1;
        n_cmp++;
        if (ext_rvalid !== 1'b0 || ext_rdata !== 64'h0 || cpu_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL inflight_drop: ext_rvalid=%b ext_rdata=%h cpu_rvalid=%b want 0/0/0", ext_rvalid, ext_rdata, cpu_rvalid);
        end
        step();
        rst = 0;
        idle();
        #1;
        n_cmp++;
        if (ext_rvalid !== 1'b0 || cpu_rvalid !== 1'b0 || dut.state_q !== ARB || dut.u_cnt.cnt_q !== 8'd0) begin
            n_fail++;
            $display("FAIL inflight_after: ext_rvalid=%b cpu_rvalid=%b state=%0d cnt=%0d want 0/0/0/0", ext_rvalid, cpu_rvalid, dut.state_q, dut.u_cnt.cnt_q);
        end
        step();
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_starvation();
        test_burst();
        test_alternate();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
